// File: rtl/mc_control_unit.sv
// Main sequencing FSM of the multicycle 16-bit RISC core; all datapath controls are decoded from state.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap opcodes 10-15 into a sticky HALT state.
module mc_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       extop,
  output logic       reg_write,
  output logic       wb_sel,
  output logic [3:0] state
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_HALT     = 4'd11;
`endif

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  logic [3:0] state_q, state_d;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    extop     = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'd0, 4'd1, 4'd2: state_d = S_EXEC_R;
          4'd3, 4'd4:       state_d = S_EXEC_I;
          4'd5, 4'd6:       state_d = S_MEM_ADDR;
          4'd7, 4'd8:       state_d = S_BRANCH;
          4'd9:             state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:          state_d = S_HALT;
`else
          // PC already advanced in FETCH, so an illegal opcode simply skips.
          default:          state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        case (opcode[1:0])
          2'd0:    alu_op = ALU_AND;
          2'd1:    alu_op = ALU_ADD;
          default: alu_op = ALU_SUB;
        endcase
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        if (opcode == 4'd3) begin
          alu_op = ALU_AND;
        end else begin
          alu_op = ALU_ADD;
          extop  = 1'b1;
        end
        state_d = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        extop     = 1'b1;
        state_d   = (opcode == 4'd5) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          mdr_write = 1'b1;
          state_d   = S_WB_MEM;
        end
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op = ALU_SUB;
        extop  = 1'b1;
        if ((opcode == 4'd7 && zero) || (opcode == 4'd8 && !zero)) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
    // Reset abandons any access in the same cycle: every control is forced low.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = 2'b00;
      extop     = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
    end
  end

  assign state = reset ? S_FETCH : state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset)                  illegal_q <= 1'b0;
    else if (state_d == S_HALT) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q && !reset;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Cycle-level check of mc_control_unit against an instruction-level sequence model.
// Works in both builds; define MC_ILLEGAL_TRAP_EN to exercise the HALT trap.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write;
  logic [1:0] pc_src, alu_op;
  logic       alu_src_b, extop, reg_write, wb_sel;
  logic [3:0] state;
  logic       act_ill;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
  assign act_ill = illegal;
`else
  assign act_ill = 1'b0;
`endif

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .extop(extop), .reg_write(reg_write), .wb_sel(wb_sel),
    .state(state)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  // One record per clock cycle: inputs to apply and the full expected control word.
  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
    logic        ill;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [17:0] cv(input logic [3:0] st, input logic req, input logic we,
                                     input logic as, input logic irw, input logic mdrw,
                                     input logic pcw, input logic [1:0] ps, input logic asb,
                                     input logic [1:0] aop, input logic ext, input logic rw,
                                     input logic wbs);
    return {st, req, we, as, irw, mdrw, pcw, ps, asb, aop, ext, rw, wbs};
  endfunction

  task automatic push(input logic rst, input logic [3:0] op, input logic z, input logic rdy,
                      input logic [17:0] e, input logic ill, input string tag);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.exp = e; v.ill = ill; v.tag = tag;
    vecs.push_back(v);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle-by-cycle expected controls.
  task automatic instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    logic taken;
    for (int i = 0; i < fw; i++)
      push(0, 4'($urandom), rb(), 0, cv(0,1,0,0,0,0,0,2'b00,0,2'b00,0,0,0), 0, "fetch_wait");
    push(0, 4'($urandom), rb(), 1, cv(0,1,0,0,1,0,1,2'b00,0,2'b00,0,0,0), 0, "fetch");
    push(0, op, rb(), rb(), cv(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0), 0, "decode");
    case (op)
      4'd0, 4'd1, 4'd2: begin
        push(0, op, rb(), rb(),
             cv(2,0,0,0,0,0,0,2'b00,0,(op == 0) ? 2'b10 : (op == 1) ? 2'b00 : 2'b01,0,0,0),
             0, "exec_r");
        push(0, op, rb(), rb(), cv(7,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0), 0, "wb_alu");
      end
      4'd3, 4'd4: begin
        push(0, op, rb(), rb(),
             cv(3,0,0,0,0,0,0,2'b00,1,(op == 3) ? 2'b10 : 2'b00,(op == 4),0,0), 0, "exec_i");
        push(0, op, rb(), rb(), cv(7,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0), 0, "wb_alu");
      end
      4'd5: begin
        push(0, op, rb(), rb(), cv(4,0,0,0,0,0,0,2'b00,1,2'b00,1,0,0), 0, "mem_addr");
        for (int i = 0; i < mw; i++)
          push(0, op, rb(), 0, cv(5,1,0,1,0,0,0,2'b00,0,2'b00,0,0,0), 0, "mem_rd_wait");
        push(0, op, rb(), 1, cv(5,1,0,1,0,1,0,2'b00,0,2'b00,0,0,0), 0, "mem_rd");
        push(0, op, rb(), rb(), cv(8,0,0,0,0,0,0,2'b00,0,2'b00,0,1,1), 0, "wb_mem");
      end
      4'd6: begin
        push(0, op, rb(), rb(), cv(4,0,0,0,0,0,0,2'b00,1,2'b00,1,0,0), 0, "mem_addr");
        for (int i = 0; i < mw; i++)
          push(0, op, rb(), 0, cv(6,1,1,1,0,0,0,2'b00,0,2'b00,0,0,0), 0, "mem_wr_wait");
        push(0, op, rb(), 1, cv(6,1,1,1,0,0,0,2'b00,0,2'b00,0,0,0), 0, "mem_wr");
      end
      4'd7, 4'd8: begin
        taken = (op == 7) ? z : !z;
        push(0, op, z, rb(),
             cv(9,0,0,0,0,0,taken,taken ? 2'b01 : 2'b00,0,2'b01,1,0,0), 0, "branch");
      end
      4'd9: push(0, op, rb(), rb(), cv(10,0,0,0,0,0,1,2'b10,0,2'b00,0,0,0), 0, "jump");
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < mw + 2; i++)
          push(0, 4'($urandom), rb(), rb(), cv(11,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0), 1, "halt");
        push(1, op, rb(), rb(), '0, 0, "halt_reset");
`endif
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got state/ctl=%h ill=%b, expected state/ctl=%h ill=%b",
               tag, act[18:1], act[0], exp[18:1], exp[0]);
    end
  endtask

  initial begin
    // Directed cases first.
    push(1, 4'd0, 0, 1, '0, 0, "reset0");
    push(1, 4'd5, 1, 1, '0, 0, "reset1");
    instr(4'd1, 0, 0, 0);   // ADD
    instr(4'd5, 1, 2, 0);   // LW with two wait cycles
    instr(4'd3, 0, 0, 0);   // ANDI
    instr(4'd4, 0, 0, 0);   // ADDI
    instr(4'd6, 0, 1, 0);   // SW
    instr(4'd7, 0, 0, 1);   // BEQ taken
    instr(4'd8, 0, 0, 1);   // BNE not taken
    instr(4'd7, 0, 0, 0);
    instr(4'd8, 2, 0, 0);
    instr(4'd9, 0, 0, 0);
    instr(4'd0, 0, 0, 0);
    instr(4'd2, 0, 0, 0);
    // Reset in the middle of a store wait abandons the access.
    push(0, 4'd6, 0, 1, cv(0,1,0,0,1,0,1,2'b00,0,2'b00,0,0,0), 0, "fetch");
    push(0, 4'd6, 0, 0, cv(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0,0), 0, "decode");
    push(0, 4'd6, 0, 0, cv(4,0,0,0,0,0,0,2'b00,1,2'b00,1,0,0), 0, "mem_addr");
    push(0, 4'd6, 0, 0, cv(6,1,1,1,0,0,0,2'b00,0,2'b00,0,0,0), 0, "mem_wr_wait");
    push(1, 4'd6, 0, 1, '0, 0, "reset_abort");
    instr(4'd1, 0, 0, 0);
    instr(4'd12, 0, 20, 0); // illegal opcode
    instr(4'd4, 0, 0, 0);
    // Randomized traffic.
    for (int n = 0; n < 200; n++)
      instr(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), rb());

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      @(negedge clk);
      if (vecs[i].tag == "decode")
        $display("instr op=%0d at cycle %0d", vecs[i].op, i);
      check(vecs[i].tag,
            {state, mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
             alu_src_b, alu_op, extop, reg_write, wb_sel, act_ill},
            {vecs[i].exp, vecs[i].ill});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Main sequencing FSM of the multicycle 16-bit RISC core. Decodes the 4-bit opcode held in the instruction register and drives, per cycle, every datapath control:
- PC and IR write enables
- ALU operand and operation selects
- memory request/write strobes
- register-file write-back
- the `extop` select of the 5-bit immediate extender

It is the only block that steps the shared ALU and memory port through fetch, decode, execute, memory and write-back. It waits on a memory-ready handshake for variable-latency memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  4  IR[15:12], valid from DECODE onward
- `zero`  in  1  ALU zero flag, combinational from current ALU operands
- `mem_ready`  in  1  memory completes the access in this cycle
- `mem_req`  out  1  memory access request, held until `mem_ready`
- `mem_we`  out  1  write strobe, qualified by `mem_req`
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR from memory data
- `mdr_write`  out  1  load MDR from memory data
- `pc_write`  out  1  load PC
- `pc_src`  out  2  PC source: 00 = PC+1, 01 = branch target (PC + sext imm), 10 = jump target
- `alu_src_b`  out  1  ALU operand B: 0 = register rs2, 1 = extended immediate
- `alu_op`  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND
- `extop`  out  1  extender mode: 1 = sign, 0 = zero
- `reg_write`  out  1  register-file write enable
- `wb_sel`  out  1  write-back source: 0 = ALUOut, 1 = MDR
- `state`  out  4  current FSM state, for debug
- `illegal`  out  1  sticky illegal-opcode flag; exists only with the configuration macro

## Operation
Opcodes:
- 0 AND, 1 ADD, 2 SUB: R-type
- 3 ANDI, 4 ADDI: I-type
- 5 LW, 6 SW
- 7 BEQ, 8 BNE
- 9 JMP
- 10–15: illegal

States (`state` encoding):
- FETCH = 0
- `DECODE` = 1
- EXEC_R = 2
- EXEC_I = 3
- MEM_ADDR = 4
- MEM_RD = 5
- MEM_WR = 6
- WB_ALU = 7
- WB_MEM = 8
- `BRANCH` = 9
- `JUMP` = 10
- HALT = 11

Transitions and per-state controls:
- `FETCH`:
  - `mem_req`=1, `addr_sel`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, next state DECODE.
  - Otherwise stay in FETCH with no writes.
- `DECODE`: no writes. Dispatch:
  - 0–2 → EXEC_R
  - 3–4 → EXEC_I
  - 5–6 → MEM_ADDR
  - 7–8 → BRANCH
  - 9 → JUMP
  - 10–15: see Configuration.
- `EXEC_R`: `alu_src_b`=0, `alu_op` = opcode[1:0] mapped as 0→10, 1→00, 2→01. Next WB_ALU.
- `EXEC_I`: `alu_src_b`=1. ANDI: `alu_op`=10, `extop`=0. ADDI: `alu_op`=00, `extop`=1. Next WB_ALU.
- `MEM_ADDR`: `alu_src_b`=1, `alu_op`=00, `extop`=1. Next MEM_RD for LW, MEM_WR for SW.
- `MEM_RD`: `mem_req`=1, `addr_sel`=1, `mem_we`=0. When `mem_ready`=1: `mdr_write`=1, next WB_MEM.
- `MEM_WR`: `mem_req`=1, `addr_sel`=1, `mem_we`=1. When `mem_ready`=1: next FETCH.
- `WB_ALU`: `reg_write`=1, `wb_sel`=0. Next FETCH.
- `WB_MEM`: `reg_write`=1, `wb_sel`=1. Next FETCH.
- `BRANCH`:
  - `alu_src_b`=0, `alu_op`=01, `extop`=1.
  - Taken when (BEQ and `zero`) or (BNE and !`zero`); if taken: `pc_write`=1, `pc_src`=01.
  - Next FETCH.
- `JUMP`: `pc_write`=1, `pc_src`=10. Next FETCH.

General rules:
- Every output not listed for a state is 0.
- `extop` is 0 in every state not listed above.
- `mem_req` is never deasserted while waiting for `mem_ready`.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.

## Timing
- Outputs are combinational from the registered state plus `opcode`, `zero` and `mem_ready`. There are no output registers.
- Reset:
  - While `reset`=1, all outputs are 0 and `state` loads FETCH (0).
  - The first cycle after `reset` falls is FETCH with `mem_req`=1.
- Reset mid-operation: the access is abandoned. `mem_req` drops in the reset cycle, and no PC, IR or register write occurs in that cycle.
- `mem_ready` may rise in the same cycle as `mem_req` (zero-wait). Each wait cycle adds exactly one cycle.
- Zero-wait latencies:
  - R-type / ANDI / ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ / BNE / JMP: 3 cycles
- The branch decision uses `zero` sampled in the BRANCH cycle.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - Opcodes 10–15 in DECODE go to HALT.
  - HALT asserts no strobes and has no exit except `reset`.
  - `illegal` is set on entry to HALT and stays 1 until `reset`.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - Opcodes 10–15 act as NOP: DECODE → FETCH, and the PC keeps the increment already applied.
  - The `illegal` port and the HALT state do not exist.

## Test plan
- ADD (opcode 1), `mem_ready` tied 1 → `state` 0,1,2,7,0. `alu_op`=00 in EXEC_R. `reg_write`=1, `wb_sel`=0 in exactly one cycle.
- LW with `mem_ready` low for 2 cycles in MEM_RD → `state` 0,1,4,5,5,5,8,0. `mem_req`=1 and `addr_sel`=1 throughout MEM_RD. `mdr_write` is pulsed only in the cycle where `mem_ready`=1.
- ANDI then ADDI → `extop`=0 in EXEC_I for ANDI, `extop`=1 for ADDI. MEM_ADDR for SW also shows `extop`=1.
- BEQ with `zero`=1 → `pc_write`=1, `pc_src`=01. BNE with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- `reset` asserted during MEM_WR wait → next cycle `mem_req`=0 and all outputs 0. After release, `state`=0 with `mem_req`=1.
- Opcode 12 → with `MC_ILLEGAL_TRAP_EN`: `state`=11 and `illegal`=1 held for 20+ cycles. Without the macro: returns to FETCH with no `reg_write`.
